// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline controller: forwarding selects, FSM states, stage indices.
package pipe_ctrl_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EXE = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_HALT     = 2'b10,
    ST_ERR      = 2'b11
  } state_e;

  localparam int unsigned NUM_STG = 5;
  localparam int unsigned STG_IF  = 0;
  localparam int unsigned STG_ID  = 1;
  localparam int unsigned STG_EXE = 2;
  localparam int unsigned STG_MEM = 3;
  localparam int unsigned STG_WB  = 4;

  localparam logic [NUM_STG-1:0] ALL_STG = NUM_STG'((1 << STG_IF) | (1 << STG_ID) |
                                                    (1 << STG_EXE) | (1 << STG_MEM) |
                                                    (1 << STG_WB));

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// RAW match detection, forwarding select (EXE > MEM > WB) and load-use stall request.
module hazard_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 5,
  parameter bit          FWD_EN = 1'b1
) (
  input  logic              rs_used,
  input  logic              rt_used,
  input  logic [ADDR_W-1:0] addr_rs,
  input  logic [ADDR_W-1:0] addr_rt,
  input  logic [ADDR_W-1:0] regw_addr_exe,
  input  logic [ADDR_W-1:0] regw_addr_mem,
  input  logic [ADDR_W-1:0] regw_addr_wb,
  input  logic              wb_wen_exe,
  input  logic              wb_wen_mem,
  input  logic              wb_wen_wb,
  input  logic              mem_ren_exe,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              load_use_c
);

  logic [2:0] hit_rs;
  logic [2:0] hit_rt;

  // Bit 0 = EXE, bit 1 = MEM, bit 2 = WB; register 0 never matches.
  function automatic logic [2:0] stage_hits(input logic used, input logic [ADDR_W-1:0] addr);
    logic live;
    live = used && (addr != '0);
    return {live && wb_wen_wb  && (addr == regw_addr_wb),
            live && wb_wen_mem && (addr == regw_addr_mem),
            live && wb_wen_exe && (addr == regw_addr_exe)};
  endfunction

  function automatic logic [1:0] pick(input logic [2:0] hits);
    if (hits[0])      return FWD_EXE;
    else if (hits[1]) return FWD_MEM;
    else if (hits[2]) return FWD_WB;
    else              return FWD_RF;
  endfunction

  always_comb begin
    hit_rs     = stage_hits(rs_used, addr_rs);
    hit_rt     = stage_hits(rt_used, addr_rt);
    fwd_a      = FWD_RF;
    fwd_b      = FWD_RF;
    load_use_c = 1'b0;
    if (FWD_EN) begin
      fwd_a      = pick(hit_rs);
      fwd_b      = pick(hit_rt);
      load_use_c = mem_ren_exe && (hit_rs[0] || hit_rt[0]);
    end else begin
      load_use_c = hit_rs[0] || hit_rt[0] || hit_rs[1] || hit_rt[1];
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// 5-stage pipeline controller: hazards/forwarding, dmem wait with timeout, debug halt/step.
// Optional perf counters built when PIPE_CTRL_PERF_CNT_EN is defined.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W      = 5,
  parameter bit          FWD_EN      = 1'b1,
  parameter int unsigned TIMEOUT_W   = 8,
  parameter int unsigned MEM_TIMEOUT = 200,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rs_used,
  input  logic                rt_used,
  input  logic [ADDR_W-1:0]   addr_rs,
  input  logic [ADDR_W-1:0]   addr_rt,
  input  logic [ADDR_W-1:0]   regw_addr_exe,
  input  logic [ADDR_W-1:0]   regw_addr_mem,
  input  logic [ADDR_W-1:0]   regw_addr_wb,
  input  logic                wb_wen_exe,
  input  logic                wb_wen_mem,
  input  logic                wb_wen_wb,
  input  logic                mem_ren_exe,
  input  logic                branch_taken_exe,
  input  logic                dmem_req,
  input  logic                dmem_ack,
  input  logic                debug_en,
  input  logic                debug_step,
  output logic [1:0]          fwd_a,
  output logic [1:0]          fwd_b,
  output logic [NUM_STG-1:0]  stage_rst,
  output logic [NUM_STG-1:0]  stage_en,
  output logic [1:0]          state,
  output logic                timeout_err,
  output logic [CNT_W-1:0]    perf_stall_cnt,
  output logic [CNT_W-1:0]    perf_flush_cnt,
  output logic [CNT_W-1:0]    perf_wait_cnt
);

  localparam logic [TIMEOUT_W-1:0] WAIT_LAST = TIMEOUT_W'(MEM_TIMEOUT - 1);

  state_e               state_q, state_d;
  logic [TIMEOUT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic                 step_prev_q, step_prev_d;
  logic                 timeout_err_q, timeout_err_d;
  logic                 load_use_c;
  logic                 step_edge;
  logic                 dmem_miss;
  logic                 advance;

  hazard_detect #(
    .ADDR_W (ADDR_W),
    .FWD_EN (FWD_EN)
  ) u_hazard (
    .rs_used       (rs_used),
    .rt_used       (rt_used),
    .addr_rs       (addr_rs),
    .addr_rt       (addr_rt),
    .regw_addr_exe (regw_addr_exe),
    .regw_addr_mem (regw_addr_mem),
    .regw_addr_wb  (regw_addr_wb),
    .wb_wen_exe    (wb_wen_exe),
    .wb_wen_mem    (wb_wen_mem),
    .wb_wen_wb     (wb_wen_wb),
    .mem_ren_exe   (mem_ren_exe),
    .fwd_a         (fwd_a),
    .fwd_b         (fwd_b),
    .load_use_c    (load_use_c)
  );

  assign step_edge = debug_step && !step_prev_q;
  assign dmem_miss = dmem_req && !dmem_ack;

  // Next state; 'advance' is low on every frozen cycle.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    advance       = 1'b0;
    step_prev_d   = debug_step;
    unique case (state_q)
      ST_RUN: begin
        advance = !dmem_miss;
        if (dmem_miss)     state_d = ST_MEM_WAIT;
        else if (debug_en) state_d = ST_HALT;
      end
      ST_MEM_WAIT: begin
        if (dmem_ack) begin
          advance    = 1'b1;
          wait_cnt_d = '0;
          state_d    = debug_en ? ST_HALT : ST_RUN;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d = ST_ERR;
        end else begin
          wait_cnt_d = wait_cnt_q + TIMEOUT_W'(1);
        end
      end
      ST_HALT: begin
        if (step_edge && dmem_miss) begin
          state_d = ST_MEM_WAIT;
        end else begin
          advance = step_edge;
          if (!debug_en) state_d = ST_RUN;
        end
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
    endcase
    timeout_err_d = timeout_err_q || (state_d == ST_ERR);
  end

  // Freeze holds everything so a pending flush is replayed once the pipe moves again.
  always_comb begin
    stage_en  = ALL_STG;
    stage_rst = '0;
    if (rst) begin
      stage_rst = ALL_STG;
    end else if (!advance) begin
      stage_en = '0;
    end else if (branch_taken_exe) begin
      stage_rst[STG_ID]  = 1'b1;
      stage_rst[STG_EXE] = 1'b1;
    end else if (load_use_c) begin
      stage_en[STG_IF]   = 1'b0;
      stage_en[STG_ID]   = 1'b0;
      stage_rst[STG_EXE] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RUN;
      wait_cnt_q    <= '0;
      step_prev_q   <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      step_prev_q   <= step_prev_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign state       = state_q;
  assign timeout_err = timeout_err_q;

`ifdef PIPE_CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] wcyc_cnt_q, wcyc_cnt_d;

  // Saturating event counters; frozen cycles never count as stall or flush.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    wcyc_cnt_d  = wcyc_cnt_q;
    if (advance && !branch_taken_exe && load_use_c && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (advance && branch_taken_exe && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    if ((state_q == ST_MEM_WAIT) && (wcyc_cnt_q != '1))
      wcyc_cnt_d = wcyc_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      wcyc_cnt_q  <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      wcyc_cnt_q  <= wcyc_cnt_d;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
  assign perf_wait_cnt  = wcyc_cnt_q;
`else
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
  assign perf_wait_cnt  = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: forwarding and no-forwarding instances vs. a cycle reference model.
module tb_pipe_ctrl;

  localparam int unsigned AW  = 5;
  localparam int unsigned CW  = 32;
  localparam int unsigned TMO = 200;

  logic          clk = 1'b0;
  logic          rst;
  logic          rs_used, rt_used;
  logic [AW-1:0] addr_rs, addr_rt;
  logic [AW-1:0] regw_addr_exe, regw_addr_mem, regw_addr_wb;
  logic          wb_wen_exe, wb_wen_mem, wb_wen_wb;
  logic          mem_ren_exe, branch_taken_exe;
  logic          dmem_req, dmem_ack, debug_en, debug_step;

  logic [1:0]    fwd_a, fwd_b, fwd_a0, fwd_b0;
  logic [4:0]    stage_rst, stage_en, stage_rst0, stage_en0;
  logic [1:0]    state, state0;
  logic          timeout_err, timeout_err0;
  logic [CW-1:0] perf_stall_cnt, perf_flush_cnt, perf_wait_cnt;
  logic [CW-1:0] perf_stall_cnt0, perf_flush_cnt0, perf_wait_cnt0;

  pipe_ctrl #(.ADDR_W(AW), .FWD_EN(1'b1), .TIMEOUT_W(8), .MEM_TIMEOUT(TMO), .CNT_W(CW)) u_fwd (
    .clk(clk), .rst(rst), .rs_used(rs_used), .rt_used(rt_used),
    .addr_rs(addr_rs), .addr_rt(addr_rt),
    .regw_addr_exe(regw_addr_exe), .regw_addr_mem(regw_addr_mem), .regw_addr_wb(regw_addr_wb),
    .wb_wen_exe(wb_wen_exe), .wb_wen_mem(wb_wen_mem), .wb_wen_wb(wb_wen_wb),
    .mem_ren_exe(mem_ren_exe), .branch_taken_exe(branch_taken_exe),
    .dmem_req(dmem_req), .dmem_ack(dmem_ack), .debug_en(debug_en), .debug_step(debug_step),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stage_rst(stage_rst), .stage_en(stage_en),
    .state(state), .timeout_err(timeout_err),
    .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt), .perf_wait_cnt(perf_wait_cnt)
  );

  pipe_ctrl #(.ADDR_W(AW), .FWD_EN(1'b0), .TIMEOUT_W(8), .MEM_TIMEOUT(TMO), .CNT_W(CW)) u_nofwd (
    .clk(clk), .rst(rst), .rs_used(rs_used), .rt_used(rt_used),
    .addr_rs(addr_rs), .addr_rt(addr_rt),
    .regw_addr_exe(regw_addr_exe), .regw_addr_mem(regw_addr_mem), .regw_addr_wb(regw_addr_wb),
    .wb_wen_exe(wb_wen_exe), .wb_wen_mem(wb_wen_mem), .wb_wen_wb(wb_wen_wb),
    .mem_ren_exe(mem_ren_exe), .branch_taken_exe(branch_taken_exe),
    .dmem_req(dmem_req), .dmem_ack(dmem_ack), .debug_en(debug_en), .debug_step(debug_step),
    .fwd_a(fwd_a0), .fwd_b(fwd_b0), .stage_rst(stage_rst0), .stage_en(stage_en0),
    .state(state0), .timeout_err(timeout_err0),
    .perf_stall_cnt(perf_stall_cnt0), .perf_flush_cnt(perf_flush_cnt0), .perf_wait_cnt(perf_wait_cnt0)
  );

  always #5 clk = ~clk;

  // Reference model: 0 RUN, 1 MEM_WAIT, 2 HALT, 3 ERR (the visible state code).
  int          m_st;
  int          m_wlen;
  bit          m_prev;
  logic [31:0] m_stall1, m_stall0, m_flush, m_wait;
  int          n_checks = 0;
  int          n_err    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit hit(input bit used, input logic [AW-1:0] a, input bit wen, input logic [AW-1:0] d);
    return used && (a != '0) && wen && (a == d);
  endfunction

  function automatic logic [1:0] exp_fwd(input bit fen, input bit used, input logic [AW-1:0] a);
    if (!fen) return 2'd0;
    if (hit(used, a, wb_wen_exe, regw_addr_exe)) return 2'd1;
    if (hit(used, a, wb_wen_mem, regw_addr_mem)) return 2'd2;
    if (hit(used, a, wb_wen_wb,  regw_addr_wb))  return 2'd3;
    return 2'd0;
  endfunction

  function automatic bit exp_stall(input bit fen);
    bit ex, me;
    ex = hit(rs_used, addr_rs, wb_wen_exe, regw_addr_exe) || hit(rt_used, addr_rt, wb_wen_exe, regw_addr_exe);
    me = hit(rs_used, addr_rs, wb_wen_mem, regw_addr_mem) || hit(rt_used, addr_rt, wb_wen_mem, regw_addr_mem);
    return fen ? (mem_ren_exe && ex) : (ex || me);
  endfunction

  // Does the pipe move this cycle?
  function automatic bit exp_adv();
    bit miss, stp;
    miss = dmem_req && !dmem_ack;
    stp  = debug_step && !m_prev;
    case (m_st)
      0:       return !miss;
      1:       return dmem_ack;
      2:       return stp && !miss;
      default: return 1'b0;
    endcase
  endfunction

  task automatic exp_vec(input bit fen, output logic [4:0] en, output logic [4:0] sr);
    if (rst)                   begin en = 5'b11111; sr = 5'b11111; end
    else if (!exp_adv())       begin en = 5'b00000; sr = 5'b00000; end
    else if (branch_taken_exe) begin en = 5'b11111; sr = 5'b00110; end
    else if (exp_stall(fen))   begin en = 5'b11100; sr = 5'b00100; end
    else                       begin en = 5'b11111; sr = 5'b00000; end
  endtask

  task automatic check_all();
    logic [4:0] en1, sr1, en0, sr0;
    exp_vec(1'b1, en1, sr1);
    exp_vec(1'b0, en0, sr0);
    chk("fwd_a",      32'(fwd_a),      32'(exp_fwd(1'b1, rs_used, addr_rs)));
    chk("fwd_b",      32'(fwd_b),      32'(exp_fwd(1'b1, rt_used, addr_rt)));
    chk("stage_en",   32'(stage_en),   32'(en1));
    chk("stage_rst",  32'(stage_rst),  32'(sr1));
    chk("fwd_a_nf",   32'(fwd_a0),     32'(exp_fwd(1'b0, rs_used, addr_rs)));
    chk("fwd_b_nf",   32'(fwd_b0),     32'(exp_fwd(1'b0, rt_used, addr_rt)));
    chk("stage_en_nf",  32'(stage_en0),  32'(en0));
    chk("stage_rst_nf", 32'(stage_rst0), 32'(sr0));
    chk("state",      32'(state),      32'(m_st));
    chk("state_nf",   32'(state0),     32'(m_st));
    chk("timeout_err", 32'(timeout_err), 32'(m_st == 3));
`ifdef PIPE_CTRL_PERF_CNT_EN
    chk("perf_stall",    perf_stall_cnt,  m_stall1);
    chk("perf_stall_nf", perf_stall_cnt0, m_stall0);
    chk("perf_flush",    perf_flush_cnt,  m_flush);
    chk("perf_wait",     perf_wait_cnt,   m_wait);
`else
    chk("perf_stall",    perf_stall_cnt,  32'd0);
    chk("perf_stall_nf", perf_stall_cnt0, 32'd0);
    chk("perf_flush",    perf_flush_cnt,  32'd0);
    chk("perf_wait",     perf_wait_cnt,   32'd0);
`endif
  endtask

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic model_edge();
    bit adv, miss, stp;
    if (rst) begin
      m_st = 0; m_wlen = 0; m_prev = 1'b0;
      m_stall1 = '0; m_stall0 = '0; m_flush = '0; m_wait = '0;
      return;
    end
    adv  = exp_adv();
    miss = dmem_req && !dmem_ack;
    stp  = debug_step && !m_prev;
    if (m_st == 1) m_wait = sat_inc(m_wait);
    if (adv && branch_taken_exe) m_flush = sat_inc(m_flush);
    if (adv && !branch_taken_exe && exp_stall(1'b1)) m_stall1 = sat_inc(m_stall1);
    if (adv && !branch_taken_exe && exp_stall(1'b0)) m_stall0 = sat_inc(m_stall0);
    case (m_st)
      0: if (miss) begin m_st = 1; m_wlen = 0; end else if (debug_en) m_st = 2;
      1: if (dmem_ack) m_st = debug_en ? 2 : 0;
         else begin m_wlen++; if (m_wlen == int'(TMO)) m_st = 3; end
      2: if (stp && miss) begin m_st = 1; m_wlen = 0; end else if (!debug_en) m_st = 0;
      default: ;
    endcase
    m_prev = debug_step;
  endtask

  // One cycle: inputs already applied at the falling edge.
  task automatic cyc();
    #1 check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic clr();
    rs_used = 0; rt_used = 0; addr_rs = '0; addr_rt = '0;
    regw_addr_exe = '0; regw_addr_mem = '0; regw_addr_wb = '0;
    wb_wen_exe = 0; wb_wen_mem = 0; wb_wen_wb = 0;
    mem_ren_exe = 0; branch_taken_exe = 0;
    dmem_req = 0; dmem_ack = 0;
  endtask

  initial begin
    int adv_cnt;
    bit step_pat[8] = '{0, 1, 1, 0, 0, 1, 0, 0};
    clr();
    debug_en = 0; debug_step = 0; rst = 1;
    m_st = 0; m_wlen = 0; m_prev = 0;
    m_stall1 = '0; m_stall0 = '0; m_flush = '0; m_wait = '0;
    @(negedge clk);
    cyc();
    rst = 0;

    // EXE non-load producer of rs: forward from EXE, no stall.
    rs_used = 1; addr_rs = 5'd3; wb_wen_exe = 1; regw_addr_exe = 5'd3;
    #1 chk("fwd_exe", 32'(fwd_a), 32'd1);
    chk("fwd_exe_en", 32'(stage_en), 32'h1F);
    cyc();

    // Load-use on rt, then the load sits in MEM.
    clr(); mem_ren_exe = 1; wb_wen_exe = 1; regw_addr_exe = 5'd3; rt_used = 1; addr_rt = 5'd3;
    #1 chk("ldu_en", 32'(stage_en), 32'b11100);
    chk("ldu_rst", 32'(stage_rst), 32'b00100);
    cyc();
    mem_ren_exe = 0; wb_wen_exe = 0; wb_wen_mem = 1; regw_addr_mem = 5'd3;
    #1 chk("ldu_fwd_mem", 32'(fwd_b), 32'd2);
    cyc();

    // Register zero never matches.
    clr(); rs_used = 1; wb_wen_exe = 1; mem_ren_exe = 1;
    #1 chk("r0_fwd", 32'(fwd_a), 32'd0);
    chk("r0_en", 32'(stage_en), 32'h1F);
    cyc();

    // Branch flush beats load-use.
    clr(); mem_ren_exe = 1; wb_wen_exe = 1; regw_addr_exe = 5'd7; rs_used = 1; addr_rs = 5'd7;
    branch_taken_exe = 1;
    #1 chk("br_rst", 32'(stage_rst), 32'b00110);
    chk("br_en", 32'(stage_en), 32'h1F);
    cyc();

    // Memory wait: three frozen cycles then ack.
    clr(); dmem_req = 1;
    repeat (3) cyc();
    dmem_ack = 1;
    #1 chk("wait_ack_state", 32'(state), 32'd1);
    cyc();
    clr();
    #1 chk("wait_back_run", 32'(state), 32'd0);
    cyc();

    // Debug halt with two step pulses.
    debug_en = 1;
    cyc();
    adv_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      debug_step = step_pat[i];
      #1 if (stage_en != 5'b0) adv_cnt++;
      cyc();
    end
    chk("halt_steps", 32'(adv_cnt), 32'd2);
    chk("halt_state", 32'(state), 32'd2);
    debug_en = 0; debug_step = 0;
    cyc();
    #1 chk("halt_exit", 32'(state), 32'd0);
    cyc();

    // Reset in the middle of a memory wait.
    dmem_req = 1;
    repeat (2) cyc();
    rst = 1; cyc(); rst = 0; dmem_req = 0;
    cyc();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      rs_used = 1'($urandom); rt_used = 1'($urandom);
      addr_rs = 5'($urandom_range(0, 7)); addr_rt = 5'($urandom_range(0, 7));
      regw_addr_exe = 5'($urandom_range(0, 7)); regw_addr_mem = 5'($urandom_range(0, 7));
      regw_addr_wb  = 5'($urandom_range(0, 7));
      wb_wen_exe = 1'($urandom); wb_wen_mem = 1'($urandom); wb_wen_wb = 1'($urandom);
      mem_ren_exe = 1'($urandom); branch_taken_exe = ($urandom % 6) == 0;
      dmem_req = ($urandom % 5) == 0; dmem_ack = 1'($urandom);
      debug_en = ($urandom % 10) == 0; debug_step = 1'($urandom);
      rst = ($urandom % 97) == 0;
      cyc();
    end
    rst = 1; clr(); debug_en = 0; debug_step = 0;
    cyc();
    rst = 0;

    // Timeout: no ack ever, ERR after the full wait, cleared only by reset.
    dmem_req = 1;
    repeat (TMO + 1) cyc();
    #1 chk("to_state", 32'(state), 32'd3);
    chk("to_err", 32'(timeout_err), 32'd1);
    chk("to_en", 32'(stage_en), 32'd0);
    dmem_ack = 1;
    repeat (3) cyc();
    rst = 1; cyc(); rst = 0; clr();
    #1 chk("to_rst_state", 32'(state), 32'd0);
    chk("to_rst_err", 32'(timeout_err), 32'd0);
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
    $finish;
  end

endmodule
